// File: rtl/sys_defs.sv
// sys_defs: shared fetch/decode packet types and
// constants for the issue window.
package sys_defs;

   localparam int ISSUE_WAYS = 3;
   localparam int PTR_W      = 3;

   localparam logic [31:0] NOP      = 32'h0000_0013;
   localparam logic [4:0]  ZERO_REG = 5'd0;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] inst;
      logic [4:0]  dest_reg_idx;
      logic        rd_mem;
   } IF_ID_PACKET;

   localparam IF_ID_PACKET NOP_PACKET = '{
      valid:        1'b0,
      pc:           32'd0,
      inst:         NOP,
      dest_reg_idx: ZERO_REG,
      rd_mem:       1'b0
   };

   // Number of valid ways in a bundle (ways are
   // contiguous from way 0, so this is also the
   // index one past the youngest valid way).
   function automatic logic [1:0] way_count(
      input IF_ID_PACKET [ISSUE_WAYS-1:0] b
   );
      logic [1:0] cnt;
      cnt = 2'd0;
      for (int i = 0; i < ISSUE_WAYS; i++)
         cnt = cnt + {1'b0, b[i].valid};
      return cnt;
   endfunction

endpackage

// File: rtl/mod_ptr_add.sv
// mod_ptr_add: pointer plus small offset, wrapped
// modulo DEPTH with one conditional subtract.
module mod_ptr_add
   import sys_defs::*;
#(
   parameter int DEPTH = 6
) (
   input  logic [PTR_W-1:0] base,
   input  logic [1:0]       offset,
   output logic [PTR_W-1:0] sum
);

   logic [PTR_W:0] raw;

   // Offset never reaches DEPTH, so one subtract is enough.
   always_comb begin
      raw = {1'b0, base} + {{(PTR_W-1){1'b0}}, offset};
      if (raw >= (PTR_W+1)'(DEPTH))
         sum = PTR_W'(raw - (PTR_W+1)'(DEPTH));
      else
         sum = raw[PTR_W-1:0];
   end

endmodule

// File: rtl/issue_window_ctrl.sv
// issue_window_ctrl: circular buffer between fetch and
// 3-way hazard detection; retires the hazard-free prefix.
module issue_window_ctrl
   import sys_defs::*;
#(
   parameter int DEPTH = 6
) (
   input  logic                          clock,
   input  logic                          reset,
   input  IF_ID_PACKET [ISSUE_WAYS-1:0]  if_packet_in,
   input  logic                          if_valid_in,
   output logic                          if_ready_out,
   input  logic [1:0]                    rollback,
   input  logic                          stall,
   input  logic                          squash,
   output IF_ID_PACKET [ISSUE_WAYS-1:0]  id_packet_out,
   output logic [1:0]                    issue_count,
   output logic [PTR_W-1:0]              occupancy,
   output logic [31:0]                   bubble_count
);

   IF_ID_PACKET      entries [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [PTR_W-1:0] head_next;
   logic [PTR_W-1:0] tail_next;
   logic [PTR_W-1:0] rd_ptr [ISSUE_WAYS];
   logic [PTR_W-1:0] wr_ptr [ISSUE_WAYS];
   logic [PTR_W:0]   free_slots;
   logic [1:0]       avail;
   logic [1:0]       allow;
   logic [1:0]       acc_cnt;
   logic             accept;
   logic             bubble;

   for (genvar k = 0; k < ISSUE_WAYS; k++) begin : g_ways
      mod_ptr_add #(.DEPTH(DEPTH)) u_rd (
         .base   (head),
         .offset (2'(k)),
         .sum    (rd_ptr[k])
      );
      mod_ptr_add #(.DEPTH(DEPTH)) u_wr (
         .base   (tail),
         .offset (2'(k)),
         .sum    (wr_ptr[k])
      );
   end

   mod_ptr_add #(.DEPTH(DEPTH)) u_head (
      .base   (head),
      .offset (issue_count),
      .sum    (head_next)
   );

   mod_ptr_add #(.DEPTH(DEPTH)) u_tail (
      .base   (tail),
      .offset (acc_cnt),
      .sum    (tail_next)
   );

   // Retire the oldest ways detection did not hold back.
   always_comb begin
      avail = (occupancy >= PTR_W'(ISSUE_WAYS))
            ? 2'(ISSUE_WAYS) : occupancy[1:0];
      allow = 2'(ISSUE_WAYS) - rollback;
      issue_count = 2'd0;
      if (!squash && !stall)
         issue_count = (avail < allow) ? avail : allow;
   end

   // Fetch credit from registered occupancy only, so
   // ready never depends on the detection loop.
   always_comb begin
      free_slots   = (PTR_W+1)'(DEPTH) - {1'b0, occupancy};
      if_ready_out = (free_slots >= (PTR_W+1)'(ISSUE_WAYS))
                   && !squash;
      accept       = if_valid_in && if_ready_out;
      acc_cnt      = accept ? way_count(if_packet_in) : 2'd0;
   end

   // Present head entries; empty ways become NOPs so
   // they cannot raise hazards downstream.
   always_comb begin
      for (int k = 0; k < ISSUE_WAYS; k++) begin
         id_packet_out[k] = NOP_PACKET;
         if (PTR_W'(k) < occupancy)
            id_packet_out[k] = entries[rd_ptr[k]];
      end
   end

   // A bubble is a cycle with work waiting but nothing
   // retired, not caused by stall or squash.
   always_comb begin
      bubble = (occupancy != '0) && (issue_count == 2'd0)
             && !stall && !squash;
   end

   // Pointer, occupancy, storage and bubble counter update.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         head         <= '0;
         tail         <= '0;
         occupancy    <= '0;
         bubble_count <= '0;
         for (int i = 0; i < DEPTH; i++)
            entries[i] <= NOP_PACKET;
      end else begin
         if (bubble)
            bubble_count <= bubble_count + 32'd1;
         if (squash) begin
            head      <= '0;
            tail      <= '0;
            occupancy <= '0;
         end else begin
            head      <= head_next;
            tail      <= tail_next;
            occupancy <= occupancy + PTR_W'(acc_cnt)
                       - PTR_W'(issue_count);
            for (int k = 0; k < ISSUE_WAYS; k++)
               if (2'(k) < acc_cnt)
                  entries[wr_ptr[k]] <= if_packet_in[k];
         end
      end
   end

endmodule

// File: tb/tb_issue_window_ctrl.sv
// tb_issue_window_ctrl: directed stimulus with a retire-order
// scoreboard checked by an independent monitor.
module tb_issue_window_ctrl;
   import sys_defs::*;

   logic                         clock = 1'b0;
   logic                         reset;
   IF_ID_PACKET [ISSUE_WAYS-1:0] pkt_in;
   logic                         if_valid_in;
   logic                         if_ready_out;
   logic [1:0]                   rollback;
   logic                         stall;
   logic                         squash;
   IF_ID_PACKET [ISSUE_WAYS-1:0] id_packet_out;
   logic [1:0]                   issue_count;
   logic [PTR_W-1:0]             occupancy;
   logic [31:0]                  bubble_count;

   int          checks = 0;
   int          errors = 0;
   int          seq    = 0;
   logic [31:0] exp_q [$];

   issue_window_ctrl #(.DEPTH(6)) dut (
      .clock         (clock),
      .reset         (reset),
      .if_packet_in  (pkt_in),
      .if_valid_in   (if_valid_in),
      .if_ready_out  (if_ready_out),
      .rollback      (rollback),
      .stall         (stall),
      .squash        (squash),
      .id_packet_out (id_packet_out),
      .issue_count   (issue_count),
      .occupancy     (occupancy),
      .bubble_count  (bubble_count)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_nop(input string tag);
      for (int k = 0; k < ISSUE_WAYS; k++) begin
         chk({tag, "_valid"}, 32'(id_packet_out[k].valid), 32'd0);
         chk({tag, "_inst"}, id_packet_out[k].inst, NOP);
         chk({tag, "_dest"}, 32'(id_packet_out[k].dest_reg_idx), 32'd0);
         chk({tag, "_rdmem"}, 32'(id_packet_out[k].rd_mem), 32'd0);
      end
   endtask

   function automatic IF_ID_PACKET mk(input int s);
      IF_ID_PACKET p;
      p.valid        = 1'b1;
      p.pc           = 32'(s * 4);
      p.inst         = 32'hA000_0000 + 32'(s);
      p.dest_reg_idx = 5'(s);
      p.rd_mem       = 1'b0;
      return p;
   endfunction

   // One cycle: drive after the edge, check combinational
   // and registered outputs before the next edge.
   task automatic step(input logic [2:0] vmask, input logic [1:0] rb,
                       input logic stl, input logic sq,
                       input int e_occ, input int e_iss,
                       input logic e_rdy);
      @(posedge clock);
      #1;
      rollback    = rb;
      stall       = stl;
      squash      = sq;
      if_valid_in = (vmask != 3'b000);
      for (int k = 0; k < ISSUE_WAYS; k++) begin
         if (vmask[k] && e_rdy) begin
            seq++;
            pkt_in[k] = mk(seq);
            exp_q.push_back(pkt_in[k].inst);
         end else begin
            pkt_in[k]       = mk(0);
            pkt_in[k].inst  = 32'hDEAD_0000 + 32'(k);
            pkt_in[k].valid = vmask[k];
         end
      end
      #3;
      chk("occupancy", 32'(occupancy), 32'(e_occ));
      chk("issue_count", 32'(issue_count), 32'(e_iss));
      chk("if_ready_out", 32'(if_ready_out), 32'(e_rdy));
      if (sq)
         exp_q.delete();
   endtask

   // Monitor: every retired way must match the oldest
   // instruction still expected, in fetch order.
   always @(negedge clock) begin
      logic [31:0] e;
      if (reset) begin
         for (int k = 0; k < ISSUE_WAYS; k++) begin
            if (k < int'(issue_count)) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL retire_order: way %0d got %0h expected none",
                           k, id_packet_out[k].inst);
               end else begin
                  e = exp_q.pop_front();
                  chk("retire_inst", id_packet_out[k].inst, e);
                  chk("retire_valid", 32'(id_packet_out[k].valid), 32'd1);
               end
            end
         end
      end
   end

   // Fetch bundles must have valid ways contiguous from way 0.
   always @(posedge clock) begin
      if (reset && if_valid_in)
         assert ({pkt_in[2].valid, pkt_in[1].valid, pkt_in[0].valid}
                 inside {3'b001, 3'b011, 3'b111})
         else $error("FAIL contiguity: non-contiguous bundle");
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset       = 1'b0;
      if_valid_in = 1'b0;
      rollback    = 2'd0;
      stall       = 1'b0;
      squash      = 1'b0;
      pkt_in      = '0;
      #12;
      reset = 1'b1;
      #1;
      chk("rst_occupancy", 32'(occupancy), 32'd0);
      chk("rst_issue", 32'(issue_count), 32'd0);
      chk("rst_ready", 32'(if_ready_out), 32'd1);
      chk("rst_bubble", bubble_count, 32'd0);
      chk_nop("rst_way");

      step(3'b000, 2'd3, 0, 0, 0, 0, 1);
      step(3'b000, 2'd0, 0, 0, 0, 0, 1);
      chk_nop("empty_way");
      step(3'b111, 2'd0, 0, 0, 0, 0, 1);
      step(3'b111, 2'd0, 0, 0, 3, 3, 1);
      chk("first_way0", id_packet_out[0].inst, 32'hA000_0001);
      chk("first_way2", id_packet_out[2].inst, 32'hA000_0003);
      step(3'b111, 2'd0, 0, 0, 3, 3, 1);
      step(3'b111, 2'd1, 0, 0, 3, 2, 1);
      step(3'b000, 2'd0, 0, 0, 4, 3, 0);
      chk("held_way0", id_packet_out[0].inst, 32'hA000_0009);
      chk("held_way1", id_packet_out[1].inst, 32'hA000_000A);
      chk("held_way2", id_packet_out[2].inst, 32'hA000_000B);
      step(3'b111, 2'd0, 0, 0, 1, 1, 1);
      step(3'b111, 2'd3, 0, 0, 3, 0, 1);
      step(3'b111, 2'd3, 0, 0, 6, 0, 0);
      step(3'b111, 2'd0, 0, 0, 6, 3, 0);
      chk("bubble_loaduse", bubble_count, 32'd2);
      step(3'b111, 2'd0, 0, 0, 3, 3, 1);
      step(3'b111, 2'd2, 0, 0, 3, 1, 1);
      step(3'b111, 2'd1, 0, 0, 5, 2, 0);
      step(3'b011, 2'd0, 0, 0, 3, 3, 1);
      step(3'b001, 2'd3, 0, 0, 2, 0, 1);
      step(3'b111, 2'd1, 0, 0, 3, 2, 1);
      chk("bubble_mixed", bubble_count, 32'd3);
      step(3'b111, 2'd0, 0, 0, 4, 3, 0);
      step(3'b111, 2'd2, 0, 0, 1, 1, 1);
      step(3'b111, 2'd0, 1, 0, 3, 0, 1);
      step(3'b000, 2'd2, 0, 0, 6, 1, 0);
      step(3'b111, 2'd0, 0, 1, 5, 0, 0);
      step(3'b000, 2'd0, 0, 0, 0, 0, 1);
      chk_nop("squash_way");
      chk("bubble_squash", bubble_count, 32'd3);
      step(3'b111, 2'd0, 0, 0, 0, 0, 1);
      step(3'b000, 2'd0, 0, 0, 3, 3, 1);
      step(3'b111, 2'd0, 0, 1, 0, 0, 0);
      step(3'b000, 2'd0, 0, 0, 0, 0, 1);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      step(3'b111, 2'd0, 0, 0, 0, 0, 1);

      @(posedge clock);
      #1;
      if_valid_in = 1'b0;
      stall       = 1'b1;
      #2;
      reset = 1'b0;
      exp_q.delete();
      #1;
      chk("rststall_occ", 32'(occupancy), 32'd0);
      chk("rststall_bubble", bubble_count, 32'd0);
      chk("rststall_ready", 32'(if_ready_out), 32'd1);
      chk_nop("rststall_way");
      #3;
      reset = 1'b1;
      step(3'b000, 2'd0, 0, 0, 0, 0, 1);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/issue_window_ctrl.md
# issue_window_ctrl

Circular buffer and sequencer between fetch (IF/ID) and the 3-way hazard detection/forwarding stage. Each cycle it presents the oldest three buffered instructions to detection, consumes the `rollback` verdict, and retires only the hazard-free prefix. The held-back ways stay at the head of the buffer and are re-presented next cycle. It also accepts new fetch bundles under a ready/valid handshake, and handles squash and downstream stall.

## Interface
- `DEPTH`, 6: buffer entries; legal range 4..7, not required to be a power of two.
- `clock`  in  1  pipeline clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `if_packet_in`  in  3×IF_ID_PACKET  fetched bundle; way 0 is the oldest.
- `if_valid_in`  in  1  bundle offered this cycle.
- `if_ready_out`  out  1  buffer can take a full bundle.
- `rollback`  in  2  from hazard detection: the number of youngest presented ways to hold back (0–3).
- `stall`  in  1  downstream freeze; nothing retires.
- `squash`  in  1  branch/exception flush.
- `id_packet_out`  out  3×IF_ID_PACKET  head entries presented to ID/detection.
- `issue_count`  out  2  ways retired this cycle (combinational).
- `occupancy`  out  3  valid entries (registered).
- `bubble_count`  out  32  count of cycles with `occupancy` > 0 and `issue_count` = 0, excluding stall and squash cycles.

## Operation
- **State:** `head` and `tail` pointers over 0..DEPTH-1, plus `occupancy` 0..DEPTH. Pointer arithmetic is modulo DEPTH: a sum ≥ DEPTH subtracts DEPTH; no power-of-two masking.
- **Presentation:** `id_packet_out[k]` = entry `(head+k) mod DEPTH` when k < occupancy. Otherwise it is a NOP packet: valid=0, inst=`NOP`, dest_reg_idx=`ZERO_REG`, rd_mem=0. This keeps empty ways from raising hazards in detection.
- **Retire count:**
  - avail = min(occupancy, 3).
  - `issue_count` = 0 if `squash` or `stall`.
  - Otherwise `issue_count` = min(avail, 3 − rollback).
- **Fetch accept:**
  - `if_ready_out` = (DEPTH − occupancy ≥ 3) && !squash. It is derived from registered state only, with no same-cycle credit from retirement.
  - Accept = `if_valid_in && if_ready_out`.
  - The accepted count is the popcount of the way-valid bits. Valid ways must be contiguous from way 0; a non-contiguous bundle is a protocol error and is asserted in the bench.
- **Update at clock edge:**
  - head += issue_count.
  - tail += accepted count.
  - occupancy += accepted − issue_count.
  - Entries are written at `tail`, `tail+1`, `tail+2`.
- **Squash:** head, tail and occupancy all go to 0. The same-cycle fetch is dropped and nothing retires. Squash has priority over stall, fetch and rollback.
- **bubble_count:** increments by 1 per qualifying cycle and wraps at 2^32. It is not cleared by squash.
- **Reset:** asynchronous assertion clears everything immediately; outputs are valid once reset deasserts.

## Timing
- Retirement is combinational in the same cycle: `id_packet_out` → detection → `rollback` → `issue_count`. There is no register in this path.
- A held-back instruction is re-presented in way 0 on the cycle after its predecessors retire.
- Fetch-to-present latency: an instruction accepted at edge N appears on `id_packet_out` in cycle N+1, provided it is at or near the head.
- Reset values:
  - `occupancy`=0, `issue_count`=0, `bubble_count`=0.
  - `if_ready_out`=1, since DEPTH ≥ 4.
  - All `id_packet_out` are NOP.
- Boundary conditions:
  - **Full** (occupancy > DEPTH−3): ready is low even if retirement would free space in the same cycle.
  - **Empty:** all ways show NOP; `issue_count`=0 regardless of `rollback`; no bubble is counted.
  - **Wrap:** when head or tail crosses DEPTH−1 → 0, ordering is preserved.
  - **Simultaneous accept and retire:** both apply in the same edge.
  - **Reset during stall or squash:** reset wins, and the block comes up empty.

## Structure
- The NOP packet constant and the `ISSUE_WAYS`=3 constant go in the shared sys_defs package alongside IF_ID_PACKET.
- One sub-module: `mod_ptr_add`, a modulo-DEPTH pointer adder instantiated for head, tail and the read/write offsets.
- The rest is a single `always_ff` block with asynchronous clear, plus the combinational selection logic.

## Test plan
- **Reset:** deassert reset with no fetch → `occupancy`=0, ready=1, all outputs NOP, `issue_count`=0 even with `rollback`=0.
- **Full throughput:** 3-valid bundles every cycle with `rollback`=0 → `issue_count`=3 each cycle and `occupancy` steady at 3. Insts A,B,C appear in ways 0,1,2 the cycle after acceptance.
- **Partial retire:** present A,B,C with `rollback`=1 → `issue_count`=2. Next cycle C is in way 0, followed by the next bundle's first two instructions.
- **Load-use bubble:** `rollback`=3 for two cycles with occupancy 3 → `issue_count`=0 and `bubble_count` increases by 2. The buffer fills to 6, ready drops, then recovers once instructions retire.
- **Wrap:** with DEPTH=6, run 10 bundles with mixed `rollback` values → retired instruction order equals fetch order and head/tail wrap without loss.
- **Squash priority:** assert `squash` with `if_valid_in`=1 at occupancy 5 → next cycle `occupancy`=0, the squashed bundle never appears, and `bubble_count` is unchanged.
